imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-memory loader: the write side of the instruction memory that `ifetch` reads. It accepts a byte stream over a valid/ready handshake and packs bytes little-endian into WORD-bit words. It writes them to consecutive addresses of the `DP_mem32x64k` port (A/W/D) starting at a programmed base. While loading it asserts `busy_o`, which the top level uses to stall `ifetch` and to mux the memory address port.

## Interface

Parameters:
- `ADDR`, 16, word-address width (64k words).
- `WORD`, 32, data word width; must be a multiple of 8.
- `BYTES`, WORD/8, bytes per word.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  begin a load; sampled only in IDLE.
- `base_i`  in  ADDR  first word address; sampled with `start_i`.
- `len_i`  in  ADDR+1  number of words to load; sampled with `start_i`; 0 means no load.
- `byte_v_i`  in  1  byte valid.
- `byte_i`  in  8  byte data.
- `byte_rdy_o`  out  1  loader can accept a byte this cycle.
- `addr_o`  out  ADDR  memory word address (to A).
- `mem_w_o`  out  1  memory write enable (to W).
- `mem_d_o`  out  WORD  memory write data (to D).
- `busy_o`  out  1  load in progress (stall/mux select for ifetch).
- `done_o`  out  1  one-cycle pulse when a load completes.

## Operation

- States: IDLE, LOAD, WRITE. All outputs are registered.
- Reset (any time, asynchronous):
  - State goes to IDLE.
  - `addr_o`=0, `mem_w_o`=0, `mem_d_o`=0, `byte_rdy_o`=0, `busy_o`=0, `done_o`=0.
  - Byte counter and word counter are cleared; any partial word is discarded.
- IDLE:
  - If `start_i`=1 and `len_i`≠0: latch `len_i`, set `addr_o`←`base_i`, clear counters, go to LOAD.
  - If `start_i`=1 and `len_i`=0: stay in IDLE and pulse `done_o` for one cycle; no write occurs.
- LOAD:
  - `byte_rdy_o`=1 and `busy_o`=1.
  - A byte is accepted on an edge where `byte_v_i`=1 and `byte_rdy_o`=1.
  - Byte k (k=0..BYTES-1) fills bits [8k+7:8k] of the assembly register (little-endian).
  - On acceptance of byte BYTES-1: `mem_d_o`←assembled word, `mem_w_o`←1, increment the word counter, go to WRITE.
- WRITE (exactly one cycle):
  - `mem_w_o`=1, `byte_rdy_o`=0, `busy_o`=1. `addr_o` holds the target address.
  - If word count = latched len: go to IDLE; `busy_o`←0, `done_o`←1 for one cycle, `addr_o` holds the last written address.
  - Else: `addr_o`←`addr_o`+1 mod 2^ADDR, go to LOAD.
- `start_i` outside IDLE is ignored. `byte_v_i` is ignored outside LOAD.
- Address arithmetic wraps mod 2^ADDR; no error is raised.

## Timing

- `start_i` is sampled at edge N. `byte_rdy_o` and `busy_o` are high from N+1.
- The last byte of a word is accepted at edge E. `mem_w_o`=1 during cycle E..E+1, and the memory captures the write at edge E+1.
- Minimum throughput is BYTES+1 cycles per word. Gaps in `byte_v_i` stall assembly without loss.
- `done_o` rises at the edge ending the final WRITE cycle and lasts one cycle. `busy_o` falls at the same edge.
- A full 65536-word load (`len_i`=2^ADDR) writes every address once, wrapping as needed.

## Test plan

- Reset mid-LOAD after 2 bytes -> all outputs read 0 immediately. Then start base=0x0000, len=1 with bytes 0xA1..0xA4 -> single write 0xA4A3A2A1 @0x0000; the earlier partial bytes do not appear.
- Reset check: assert `rst` with no clock edge -> all outputs are 0. Deassert and idle 5 cycles -> no `mem_w_o`, no `done_o`.
- Start base=0x0010, len=2; stream bytes 0x11..0x88 back-to-back -> `0x44332211`@0x0010, then `0x88776655`@0x0011; exactly 2 `mem_w_o` pulses; `done_o` one cycle after the second write; `busy_o` high only during the load.
- Start base=0xFFFF, len=2 -> writes land at 0xFFFF then 0x0000.
- Start with len=0 -> `done_o` pulses the next cycle; `busy_o` stays 0; no write occurs.
- Random `byte_v_i` gaps, plus `start_i` pulsed while busy -> data and addresses are identical to the gap-free run; the second start has no effect; `byte_rdy_o`=0 in every WRITE cycle.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream little-endian into
// WORD-bit words and writes them to consecutive word addresses from a base.
module imem_loader #(
    parameter int ADDR  = 16,
    parameter int WORD  = 32,
    parameter int BYTES = WORD / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR-1:0]   base_i,
    input  logic [ADDR:0]     len_i,
    input  logic              byte_v_i,
    input  logic [7:0]        byte_i,
    output logic              byte_rdy_o,
    output logic [ADDR-1:0]   addr_o,
    output logic              mem_w_o,
    output logic [WORD-1:0]   mem_d_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE} state_t;

    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0] BLAST = BCW'(BYTES - 1);

    state_t            state_q, state_d;
    logic [ADDR-1:0]   addr_q, addr_d;
    logic [WORD-1:0]   mem_d_q, mem_d_d;
    logic [WORD-1:0]   asm_q, asm_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [ADDR:0]     wcnt_q, wcnt_d;
    logic [ADDR:0]     len_q, len_d;
    logic              mem_w_q, mem_w_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept, last_byte, last_word;

    assign accept    = (state_q == S_LOAD) && byte_v_i && rdy_q;
    assign last_byte = accept && (bcnt_q == BLAST);
    assign last_word = (wcnt_q == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && (len_i != '0)) state_d = S_LOAD;
            S_LOAD:  if (last_byte) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_IDLE : S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        mem_d_d = mem_d_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        len_d   = len_q;
        mem_w_d = 1'b0;
        done_d  = 1'b0;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        len_d  = len_i;
                        addr_d = base_i;
                        bcnt_d = '0;
                        wcnt_d = '0;
                        asm_d  = '0;
                        rdy_d  = 1'b1;
                        busy_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    // Byte k lands in bits [8k+7:8k]
                    for (int k = 0; k < BYTES; k++) begin
                        if (bcnt_q == BCW'(k)) asm_d[8*k +: 8] = byte_i;
                    end
                    if (last_byte) begin
                        mem_d_d = asm_d;
                        mem_w_d = 1'b1;
                        rdy_d   = 1'b0;
                        bcnt_d  = '0;
                        wcnt_d  = wcnt_q + (ADDR+1)'(1);
                    end else begin
                        bcnt_d  = bcnt_q + BCW'(1);
                    end
                end
            end
            S_WRITE: begin
                // Final word keeps addr_o on the last written address
                if (last_word) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    rdy_d  = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR'(1);
                    rdy_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            mem_d_q <= '0;
            asm_q   <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            len_q   <= '0;
            mem_w_q <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            mem_d_q <= mem_d_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            mem_w_q <= mem_w_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign addr_o     = addr_q;
    assign mem_d_o    = mem_d_q;
    assign mem_w_o    = mem_w_q;
    assign byte_rdy_o = rdy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a queue model of expected memory writes checked every
// cycle, plus directed loads with literal expectations.
module tb_imem_loader;
    localparam int ADDR = 16;
    localparam int WORD = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [ADDR-1:0]   base_i;
    logic [ADDR:0]     len_i;
    logic              byte_v_i;
    logic [7:0]        byte_i;
    logic              byte_rdy_o;
    logic [ADDR-1:0]   addr_o;
    logic              mem_w_o;
    logic [WORD-1:0]   mem_d_o;
    logic              busy_o;
    logic              done_o;

    imem_loader #(.ADDR(ADDR), .WORD(WORD)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
        .byte_v_i(byte_v_i), .byte_i(byte_i), .byte_rdy_o(byte_rdy_o),
        .addr_o(addr_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [ADDR-1:0] exp_a[$];
    logic [WORD-1:0] exp_d[$];
    logic [ADDR-1:0] log_a[$];
    logic [WORD-1:0] log_d[$];
    logic [7:0]      stream[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Every write cycle must match the next pending word of the model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_w_o) begin
                chk("wr_rdy_low", 64'(byte_rdy_o), 64'd0);
                chk("wr_busy_high", 64'(busy_o), 64'd1);
                chk("wr_pending", 64'(exp_a.size() > 0), 64'd1);
                if (exp_a.size() > 0) begin
                    chk("wr_addr", 64'(addr_o), 64'(exp_a.pop_front()));
                    chk("wr_data", 64'(mem_d_o), 64'(exp_d.pop_front()));
                end
                log_a.push_back(addr_o);
                log_d.push_back(mem_d_o);
            end
            if (done_o) begin
                done_cnt++;
                chk("done_all_written", 64'(exp_a.size()), 64'd0);
                chk("done_busy_low", 64'(busy_o), 64'd0);
            end
        end
    end

    // Model: word w of a load is stream bytes 4w..4w+3 little-endian at base+w
    task automatic model_load(input logic [ADDR-1:0] base, input int len);
        logic [WORD-1:0] d;
        for (int w = 0; w < len; w++) begin
            d = '0;
            for (int k = 0; k < WORD/8; k++) d[8*k +: 8] = stream[(WORD/8)*w + k];
            exp_a.push_back(base + ADDR'(w));
            exp_d.push_back(d);
        end
    endtask

    task automatic do_start(input logic [ADDR-1:0] base, input int len);
        start_i = 1'b1;
        base_i  = base;
        len_i   = (ADDR+1)'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        int t;
        byte_v_i = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        byte_v_i = 1'b1;
        byte_i   = b;
        t = 0;
        forever begin
            @(negedge clk); r = byte_rdy_o;
            @(posedge clk); #1;
            if (r) break;
            t++;
            if (t > 100) begin
                chk("byte_accept_timeout", 64'(t), 64'd0);
                break;
            end
        end
        byte_v_i = 1'b0;
    endtask

    task automatic run_load(input logic [ADDR-1:0] base, input int len,
                            input int maxgap, input bit poke);
        int t, d0, nb;
        d0 = done_cnt;
        model_load(base, len);
        do_start(base, len);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        chk("rdy_after_start", 64'(byte_rdy_o), 64'd1);
        nb = len * (WORD/8);
        for (int i = 0; i < nb; i++) begin
            if (poke && i == 2) begin
                byte_v_i = 1'b0;
                do_start(16'h0000, 3);
            end
            send_byte(stream[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
        chk("mem_w_after_last_byte", 64'(mem_w_o), 64'd1);
        chk("rdy_low_in_write", 64'(byte_rdy_o), 64'd0);
        t = 0;
        while (done_o !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        chk("done_latency", 64'(t), 64'd1);
        chk("busy_low_at_done", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        chk("queue_drained", 64'(exp_a.size()), 64'd0);
    endtask

    task automatic set_stream(input logic [7:0] first, input logic [7:0] step, input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(first + 8'(i) * step);
    endtask

    initial begin
        int n0, d0;
        rst = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0;
        byte_v_i = 1'b0; byte_i = '0;

        // Asynchronous reset with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_mem_w", 64'(mem_w_o), 64'd0);
        chk("rst_mem_d", 64'(mem_d_o), 64'd0);
        chk("rst_rdy", 64'(byte_rdy_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_no_write", 64'({mem_w_o, done_o, busy_o}), 64'd0);
        end

        // Reset mid-load after two bytes discards the partial word
        do_start(16'h0020, 1);
        send_byte(8'hEE, 0);
        send_byte(8'hDD, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({addr_o, mem_w_o, byte_rdy_o, busy_o, done_o}), 64'd0);
        chk("rst_mid_data", 64'(mem_d_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        n0 = log_a.size();
        stream = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        run_load(16'h0000, 1, 0, 1'b0);
        chk("after_rst_nwrites", 64'(log_a.size() - n0), 64'd1);
        chk("after_rst_data", 64'(log_d[n0]), 64'hA4A3A2A1);
        chk("after_rst_addr", 64'(log_a[n0]), 64'h0000);

        // Two words back-to-back
        n0 = log_a.size();
        set_stream(8'h11, 8'h11, 8);
        run_load(16'h0010, 2, 0, 1'b0);
        chk("b2b_nwrites", 64'(log_a.size() - n0), 64'd2);
        chk("b2b_d0", 64'(log_d[n0]), 64'h44332211);
        chk("b2b_a0", 64'(log_a[n0]), 64'h0010);
        chk("b2b_d1", 64'(log_d[n0+1]), 64'h88776655);
        chk("b2b_a1", 64'(log_a[n0+1]), 64'h0011);

        // Address wrap
        n0 = log_a.size();
        set_stream(8'h01, 8'h01, 8);
        run_load(16'hFFFF, 2, 0, 1'b0);
        chk("wrap_a0", 64'(log_a[n0]), 64'hFFFF);
        chk("wrap_a1", 64'(log_a[n0+1]), 64'h0000);
        chk("wrap_d1", 64'(log_d[n0+1]), 64'h08070605);

        // Zero-length load
        n0 = log_a.size();
        d0 = done_cnt;
        do_start(16'h0055, 0);
        chk("len0_done", 64'(done_o), 64'd1);
        chk("len0_busy", 64'(busy_o), 64'd0);
        chk("len0_rdy", 64'(byte_rdy_o), 64'd0);
        @(posedge clk); #1;
        chk("len0_done_clear", 64'(done_o), 64'd0);
        chk("len0_done_count", 64'(done_cnt - d0), 64'd1);
        chk("len0_no_write", 64'(log_a.size() - n0), 64'd0);

        // Random gaps and a start pulse while busy
        n0 = log_a.size();
        set_stream(8'h11, 8'h11, 8);
        run_load(16'h0010, 2, 3, 1'b1);
        chk("gap_nwrites", 64'(log_a.size() - n0), 64'd2);
        chk("gap_d0", 64'(log_d[n0]), 64'h44332211);
        chk("gap_a0", 64'(log_a[n0]), 64'h0010);
        chk("gap_d1", 64'(log_d[n0+1]), 64'h88776655);
        chk("gap_a1", 64'(log_a[n0+1]), 64'h0011);
        repeat (4) begin
            @(posedge clk); #1;
            chk("gap_idle_after", 64'({busy_o, mem_w_o}), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
